// File: rtl/rename_table_if.sv
// rename_table_if: decoder/ROB-facing bundle for the register alias table
interface rename_table_if #(
  parameter int ROB_DEPTH = 32,
  parameter int GPR_NUM = 32,
  parameter int GPR_ADDR_WIDTH = 5
);
  localparam int TAG_W = $clog2(ROB_DEPTH);
  localparam int CNT_W = $clog2(GPR_NUM) + 1;
  logic alloc_en, alloc_dst_wen, commit_en, commit_dst_wen, flush;
  logic rs1_rat_valid, rs2_rat_valid;
  logic [GPR_ADDR_WIDTH-1:0] alloc_dst_addr, commit_dst_addr, rs1_addr, rs2_addr;
  logic [TAG_W-1:0] alloc_tag, commit_Paddr, rs1_Paddr, rs2_Paddr;
  logic [CNT_W-1:0] mapped_cnt;
  modport master (
    output alloc_en, alloc_dst_addr, alloc_dst_wen, alloc_tag, rs1_addr, rs2_addr,
    output commit_en, commit_dst_addr, commit_dst_wen, commit_Paddr, flush,
    input rs1_rat_valid, rs2_rat_valid, rs1_Paddr, rs2_Paddr, mapped_cnt
  );
  modport slave (
    input alloc_en, alloc_dst_addr, alloc_dst_wen, alloc_tag, rs1_addr, rs2_addr,
    input commit_en, commit_dst_addr, commit_dst_wen, commit_Paddr, flush,
    output rs1_rat_valid, rs2_rat_valid, rs1_Paddr, rs2_Paddr, mapped_cnt
  );
endinterface

// File: rtl/rename_table.sv
// rename_table: maps each architectural GPR to the ROB tag of its newest in-flight producer
module rename_table #(
  parameter int ROB_DEPTH = 32,
  parameter int GPR_NUM = 32,
  parameter int GPR_ADDR_WIDTH = 5,
  localparam int TAG_W = $clog2(ROB_DEPTH),
  localparam int CNT_W = $clog2(GPR_NUM) + 1
) (
  input logic clk,
  input logic rst,
  rename_table_if.slave rt
);
  logic [GPR_NUM-1:0] valid, valid_nxt;
  logic [TAG_W-1:0] tag [GPR_NUM];
  logic [CNT_W-1:0] cnt, cnt_nxt;
  logic [GPR_ADDR_WIDTH-1:0] ad, cd;
  logic alloc_hit, commit_hit;
  assign ad = rt.alloc_dst_addr;
  assign cd = rt.commit_dst_addr;
  assign alloc_hit = rt.alloc_en && rt.alloc_dst_wen && ad != '0;
  assign commit_hit = rt.commit_en && rt.commit_dst_wen && valid[cd] && tag[cd] == rt.commit_Paddr;
  assign rt.rs1_rat_valid = valid[rt.rs1_addr];
  assign rt.rs2_rat_valid = valid[rt.rs2_addr];
  assign rt.rs1_Paddr = tag[rt.rs1_addr];
  assign rt.rs2_Paddr = tag[rt.rs2_addr];
  assign rt.mapped_cnt = cnt;
  // next valid vector: commit clear, then allocate (so allocate wins), flush clears all
  always_comb begin
    valid_nxt = valid;
    if (commit_hit) valid_nxt[cd] = 1'b0;
    if (alloc_hit) valid_nxt[ad] = 1'b1;
    valid_nxt[0] = 1'b0;
    if (rt.flush) valid_nxt = '0;
  end
  // population count of the next valid vector so mapped_cnt tracks the table edge for edge
  always_comb begin
    cnt_nxt = '0;
    for (int i = 1; i < GPR_NUM; i++) cnt_nxt = cnt_nxt + CNT_W'(valid_nxt[i]);
  end
  // table state; tags survive flush (valid gates them) but reset zeroes them
  always_ff @(posedge clk) begin
    if (rst) begin
      valid <= '0;
      cnt <= '0;
      for (int i = 0; i < GPR_NUM; i++) tag[i] <= '0;
    end else begin
      valid <= valid_nxt;
      cnt <= cnt_nxt;
      if (alloc_hit && !rt.flush) tag[ad] <= rt.alloc_tag;
    end
  end
endmodule

// File: doc/rename_table.md
# rename_table

Register alias table (RAT) between the decoder and the reorder buffer. It maps each architectural GPR to the ROB entry holding its newest in-flight producer. For rs1/rs2 it returns the mapping tag and a valid bit, which the ROB uses to source operands. It is updated by ROB allocation and commit, and is cleared on a branch-taken or exception flush.

## Interface
Parameters:
- ROB_DEPTH, 32: ROB entries; TAG_W = $clog2(ROB_DEPTH).
- GPR_NUM, 32: architectural registers.
- GPR_ADDR_WIDTH, 5: architectural register index width.

Ports:
- clk  in  1  clock; all state updates on the rising edge.
- rst  in  1  reset, synchronous, active-high.
- alloc_en  in  1  ROB is allocating an entry this cycle.
- alloc_dst_addr  in  GPR_ADDR_WIDTH  destination register (Aaddr) of the allocated instruction.
- alloc_dst_wen  in  1  the allocated instruction writes its destination register.
- alloc_tag  in  TAG_W  ROB index (Paddr) being allocated.
- rs1_addr, rs2_addr  in  GPR_ADDR_WIDTH each  source registers of the instruction being allocated.
- rs1_rat_valid, rs2_rat_valid  out  1 each  source is mapped to an in-flight ROB entry.
- rs1_Paddr, rs2_Paddr  out  TAG_W each  ROB tag of the mapped source.
- commit_en  in  1  ROB head is committing this cycle.
- commit_dst_addr  in  GPR_ADDR_WIDTH  Aaddr of the committing entry.
- commit_dst_wen  in  1  committing entry writes its destination register.
- commit_Paddr  in  TAG_W  ROB index of the committing entry.
- flush  in  1  commit-time branch-taken or exception; all speculative mappings are discarded.
- mapped_cnt  out  $clog2(GPR_NUM)+1  number of registers currently mapped (registered).

## Operation
- Each register has a `valid` bit and a `tag[TAG_W]`. Register x0 is never mapped: its valid bit is held at 0.
- **Read:** purely combinational from the registered table.
  - rsN_rat_valid = valid[rsN_addr]; rsN_Paddr = tag[rsN_addr].
  - An instruction whose rd equals its rs reads the older mapping. Its own allocation takes effect only at the next edge.
- **Allocate:** when alloc_en && alloc_dst_wen && alloc_dst_addr != 0, next valid[dst] = 1 and tag[dst] = alloc_tag. Any older mapping is overwritten.
- **Commit clear:** when commit_en && commit_dst_wen && valid[commit_dst_addr] && tag[commit_dst_addr] == commit_Paddr, next valid = 0. The value now lives in the GPR. If the tag does not match, a younger producer exists and the mapping is untouched.
- **Simultaneous allocate and commit to the same register:** allocate wins, and the new tag is written with valid = 1.
- **Flush:** overrides everything. All valid bits are cleared at the next edge. Allocate and commit-clear in the flush cycle are ignored.
- **mapped_cnt:** registered population count of the valid bits. It must equal the count of valid bits after every edge. The range is 0..31 (x0 excluded).
- **Reset:** all valid = 0, all tags = 0, mapped_cnt = 0. Consequently rs1/rs2_rat_valid = 0 and rs1/rs2_Paddr = 0 in the first cycle after reset.
- Reset mid-operation behaves like flush and also zeroes the tags.

## Timing
- Read latency: 0 cycles (same-cycle combinational).
- Update latency: 1 cycle. An allocation at edge t is visible to reads in cycle t+1.
- Back-to-back dependent instructions need no bypass, because the decoder allocates one instruction per cycle.
- A read in the same cycle as a matching commit-clear returns valid = 1 with the old tag. That is correct, because the ROB entry still holds ready data in that cycle.
- mapped_cnt updates at the same edge as the table.
- No stalls and no handshake. The block accepts every alloc/commit the ROB presents.

## Test plan
- **Reset:** hold rst for 2 cycles, then read rs1 = 5, rs2 = 31 -> both rat_valid = 0, Paddr = 0, mapped_cnt = 0.
- **Allocate then read:** alloc x3 with tag 7 at cycle 0. A read of rs1 = 3 in cycle 0 gives valid = 0. In cycle 1 it gives valid = 1, Paddr = 7, and mapped_cnt = 1.
- **Rename chain:** alloc x3 with tag 7, then x3 with tag 8. Commit tag 7 (dst x3) -> x3 still maps to tag 8 with valid = 1. Commit tag 8 -> x3 valid = 0 and mapped_cnt = 0.
- **Same-cycle allocate and commit:** x4 maps to tag 2. In one cycle, commit tag 2 (dst x4) and alloc x4 with tag 9 -> next cycle x4 has valid = 1, Paddr = 9.
- **x0 and no-write:**
  - alloc x0 with tag 1 -> x0 stays valid = 0.
  - alloc x6 with alloc_dst_wen = 0 -> x6 is unmapped and mapped_cnt is unchanged.
- **Flush:** map x1..x10 with tags 0..9 (mapped_cnt = 10), then assert flush together with alloc x11 tag 10 -> next cycle all valid = 0, x11 is unmapped, and mapped_cnt = 0.
